cdb_arbiter: RTL and testbench

- Parametrised, registered successor to the 5-input fixed-priority done selector.
- Arbitrates N functional-unit "done" requests onto up to NUM_GRANT CDB ports per cycle.
- Supports fixed priority (highest index wins) and round-robin modes, plus a CDB stall.
- Sits between the functional-unit done signals and the CDB driver; its ack tells each unit its result was broadcast.

---
 rtl/cdb_arbiter_pkg.sv | 15 +
 rtl/cdb_arbiter_rr_scan.sv | 36 +++
 rtl/cdb_arbiter.sv | 98 +++++++++
 tb/tb_cdb_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the CDB arbiter slice: default functional-unit and
// CDB port counts, the index type, and the wrap-around decrement used for scanning.
package cdb_arbiter_pkg;

    localparam int NUM_FU   = 5;
    localparam int NUM_CDB  = 1;
    localparam int FU_IDX_W = $clog2(NUM_FU);

    typedef logic [FU_IDX_W-1:0] fu_idx_t;

    function automatic int dec_wrap(input int v, input int n);
        return (v == 0) ? (n - 1) : (v - 1);
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_scan.sv
// Combinational scanner: finds the first eligible requester, starting at
// start_i and descending with wrap-around (start, start-1, ..., 0, N-1, ...).
module cdb_arbiter_rr_scan
    import cdb_arbiter_pkg::*;
#(
    parameter  int N     = NUM_FU,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     elig_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    logic [IDX_W-1:0] pos_s;

    // Walk N positions in descending-wrap order; the first hit wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = {IDX_W{1'b0}};
        if (int'(start_i) < N) begin
            pos_s = start_i;
        end else begin
            pos_s = IDX_W'(N - 1);
        end
        for (int k = 0; k < N; k++) begin
            if (!found_o && elig_i[pos_s]) begin
                found_o = 1'b1;
                idx_o   = pos_s;
            end else begin
                pos_s = IDX_W'(dec_wrap(int'(pos_s), N));
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Registered CDB arbiter: grants up to NUM_GRANT functional-unit done requests
// per cycle, fixed (highest index first) or round-robin priority, with stall.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter  int N         = NUM_FU,
    parameter  int NUM_GRANT = NUM_CDB,
    localparam int IDX_W     = $clog2(N),
    localparam int CNT_W     = $clog2(NUM_GRANT + 1)
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       rr_en_i,
    input  logic                       stall_i,
    input  logic [N-1:0]               req_i,
    output logic [N-1:0]               ack_o,
    output logic [NUM_GRANT-1:0]       ack_valid_o,
    output logic [NUM_GRANT*IDX_W-1:0] ack_idx_o,
    output logic [CNT_W-1:0]           num_granted_o
);

    logic [N-1:0]               ack_q,   ack_d;
    logic [NUM_GRANT-1:0]       valid_q, valid_d;
    logic [NUM_GRANT*IDX_W-1:0] idx_q,   idx_d;
    logic [CNT_W-1:0]           cnt_q,   cnt_d;
    logic [IDX_W-1:0]           ptr_q,   ptr_d;

    logic [N-1:0]               elig_s;
    logic [IDX_W-1:0]           start_s;
    logic [N-1:0]               mask_s      [NUM_GRANT+1];
    logic [IDX_W-1:0]           win_idx_s   [NUM_GRANT];
    logic [NUM_GRANT-1:0]       win_found_s;

    // A unit acked this cycle still holds req high, so it must not win again.
    assign elig_s    = req_i & ~ack_q;
    assign start_s   = rr_en_i ? ptr_q : IDX_W'(N - 1);
    assign mask_s[0] = elig_s;

    // Every stage scans from the same start; earlier winners are masked out,
    // so the chain yields winners in scan order.
    for (genvar g = 0; g < NUM_GRANT; g++) begin : g_scan
        cdb_arbiter_rr_scan #(.N(N)) u_scan (
            .elig_i  (mask_s[g]),
            .start_i (start_s),
            .idx_o   (win_idx_s[g]),
            .found_o (win_found_s[g])
        );
        assign mask_s[g+1] = mask_s[g] &
            ~(win_found_s[g] ? ({{(N-1){1'b0}}, 1'b1} << win_idx_s[g]) : {N{1'b0}});
    end

    // Next-state: pack winners from port 0, pointer follows the last winner.
    always_comb begin
        ack_d   = {N{1'b0}};
        valid_d = {NUM_GRANT{1'b0}};
        idx_d   = {(NUM_GRANT*IDX_W){1'b0}};
        cnt_d   = {CNT_W{1'b0}};
        ptr_d   = ptr_q;
        if (stall_i) begin
            ptr_d = ptr_q;
        end else begin
            ack_d = elig_s & ~mask_s[NUM_GRANT];
            for (int g = 0; g < NUM_GRANT; g++) begin
                if (win_found_s[g]) begin
                    valid_d[g]               = 1'b1;
                    idx_d[g*IDX_W +: IDX_W]  = win_idx_s[g];
                    cnt_d                    = cnt_d + CNT_W'(1);
                    ptr_d                    = IDX_W'(dec_wrap(int'(win_idx_s[g]), N));
                end else begin
                    valid_d[g] = 1'b0;
                end
            end
        end
    end

    // Output and pointer registers with synchronous reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            ack_q   <= {N{1'b0}};
            valid_q <= {NUM_GRANT{1'b0}};
            idx_q   <= {(NUM_GRANT*IDX_W){1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            ptr_q   <= IDX_W'(N - 1);
        end else begin
            ack_q   <= ack_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign ack_o         = ack_q;
    assign ack_valid_o   = valid_q;
    assign ack_idx_o     = idx_q;
    assign num_granted_o = cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: one single-port and one dual-port instance
// driven with directed vectors; a monitor compares each cycle's outputs.
module tb_cdb_arbiter;

    logic       clk = 1'b0;
    logic       rst, rr, st;
    logic [4:0] req_a, req_b;

    logic [4:0] ack_a;
    logic       ackv_a;
    logic [2:0] idx_a;
    logic       cnt_a;

    logic [4:0] ack_b;
    logic [1:0] ackv_b;
    logic [5:0] idx_b;
    logic [1:0] cnt_b;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit         sel;
        logic [4:0] ack;
        logic [1:0] valid;
        logic [2:0] i0;
        logic [2:0] i1;
        logic [1:0] cnt;
        logic [2:0] ptr;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    always #5 clk = ~clk;

    cdb_arbiter #(.N(5), .NUM_GRANT(1)) u_a (
        .clock_i       (clk),
        .reset_i       (rst),
        .rr_en_i       (rr),
        .stall_i       (st),
        .req_i         (req_a),
        .ack_o         (ack_a),
        .ack_valid_o   (ackv_a),
        .ack_idx_o     (idx_a),
        .num_granted_o (cnt_a)
    );

    cdb_arbiter #(.N(5), .NUM_GRANT(2)) u_b (
        .clock_i       (clk),
        .reset_i       (rst),
        .rr_en_i       (rr),
        .stall_i       (st),
        .req_i         (req_b),
        .ack_o         (ack_b),
        .ack_valid_o   (ackv_b),
        .ack_idx_o     (idx_b),
        .num_granted_o (cnt_b)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Drive one cycle of stimulus and queue the outputs expected after the edge.
    task automatic step(input bit sel, input logic r, input logic m, input logic s,
                        input logic [4:0] rq, input logic [4:0] eack,
                        input logic [1:0] ev, input logic [2:0] e0, input logic [2:0] e1,
                        input logic [1:0] ec, input logic [2:0] ep);
        exp_t e;
        @(negedge clk);
        rst = r;
        rr  = m;
        st  = s;
        if (sel) begin
            req_a = 5'b00000;
            req_b = rq;
        end else begin
            req_a = rq;
            req_b = 5'b00000;
        end
        e.sel = sel; e.ack = eack; e.valid = ev; e.i0 = e0; e.i1 = e1;
        e.cnt = ec;  e.ptr = ep;
        sb.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            if (cur.sel) begin
                chk("b_ack",   8'(ack_b),       8'(cur.ack));
                chk("b_valid", 8'(ackv_b),      8'(cur.valid));
                chk("b_idx0",  8'(idx_b[2:0]),  8'(cur.i0));
                chk("b_idx1",  8'(idx_b[5:3]),  8'(cur.i1));
                chk("b_cnt",   8'(cnt_b),       8'(cur.cnt));
                chk("b_ptr",   8'(u_b.ptr_q),   8'(cur.ptr));
            end else begin
                chk("a_ack",   8'(ack_a),       8'(cur.ack));
                chk("a_valid", 8'(ackv_a),      8'(cur.valid[0]));
                chk("a_idx",   8'(idx_a),       8'(cur.i0));
                chk("a_cnt",   8'(cnt_a),       8'(cur.cnt[0]));
                chk("a_ptr",   8'(u_a.ptr_q),   8'(cur.ptr));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; rr = 1'b0; st = 1'b0; req_a = 5'b0; req_b = 5'b0;

        // Single-port, fixed priority: reset and basic grants.
        step(0, 1, 0, 0, 5'b00000, 5'b00000, 2'd0, 3'd0, 3'd0, 2'd0, 3'd4);
        step(0, 1, 0, 0, 5'b10101, 5'b00000, 2'd0, 3'd0, 3'd0, 2'd0, 3'd4);
        step(0, 0, 0, 0, 5'b00000, 5'b00000, 2'd0, 3'd0, 3'd0, 2'd0, 3'd4);
        step(0, 0, 0, 0, 5'b10000, 5'b10000, 2'd1, 3'd4, 3'd0, 2'd1, 3'd3);
        step(0, 0, 0, 0, 5'b00000, 5'b00000, 2'd0, 3'd0, 3'd0, 2'd0, 3'd3);
        step(0, 0, 0, 0, 5'b10100, 5'b10000, 2'd1, 3'd4, 3'd0, 2'd1, 3'd3);
        step(0, 0, 0, 0, 5'b00100, 5'b00100, 2'd1, 3'd2, 3'd0, 2'd1, 3'd1);
        step(0, 0, 0, 0, 5'b00000, 5'b00000, 2'd0, 3'd0, 3'd0, 2'd0, 3'd1);
        step(0, 0, 0, 0, 5'b01111, 5'b01000, 2'd1, 3'd3, 3'd0, 2'd1, 3'd2);
        step(0, 0, 0, 0, 5'b00111, 5'b00100, 2'd1, 3'd2, 3'd0, 2'd1, 3'd1);
        step(0, 0, 0, 0, 5'b00011, 5'b00010, 2'd1, 3'd1, 3'd0, 2'd1, 3'd0);
        step(0, 0, 0, 0, 5'b00001, 5'b00001, 2'd1, 3'd0, 3'd0, 2'd1, 3'd4);
        step(0, 0, 0, 0, 5'b00000, 5'b00000, 2'd0, 3'd0, 3'd0, 2'd0, 3'd4);
        // Request held one cycle past its ack is granted only once.
        step(0, 0, 0, 0, 5'b00010, 5'b00010, 2'd1, 3'd1, 3'd0, 2'd1, 3'd0);
        step(0, 0, 0, 0, 5'b00010, 5'b00000, 2'd0, 3'd0, 3'd0, 2'd0, 3'd0);
        step(0, 0, 0, 0, 5'b00000, 5'b00000, 2'd0, 3'd0, 3'd0, 2'd0, 3'd0);

        // Round robin with each unit dropping req for one cycle after its ack.
        step(0, 1, 1, 0, 5'b00000, 5'b00000, 2'd0, 3'd0, 3'd0, 2'd0, 3'd4);
        step(0, 0, 1, 0, 5'b11111, 5'b10000, 2'd1, 3'd4, 3'd0, 2'd1, 3'd3);
        step(0, 0, 1, 0, 5'b01111, 5'b01000, 2'd1, 3'd3, 3'd0, 2'd1, 3'd2);
        step(0, 0, 1, 0, 5'b10111, 5'b00100, 2'd1, 3'd2, 3'd0, 2'd1, 3'd1);
        step(0, 0, 1, 0, 5'b11011, 5'b00010, 2'd1, 3'd1, 3'd0, 2'd1, 3'd0);
        step(0, 0, 1, 0, 5'b11101, 5'b00001, 2'd1, 3'd0, 3'd0, 2'd1, 3'd4);
        step(0, 0, 1, 0, 5'b11110, 5'b10000, 2'd1, 3'd4, 3'd0, 2'd1, 3'd3);
        step(0, 0, 1, 0, 5'b00000, 5'b00000, 2'd0, 3'd0, 3'd0, 2'd0, 3'd3);

        // Stall holds grants off and keeps the pointer.
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 1, 5'b00011, 5'b00000, 2'd0, 3'd0, 3'd0, 2'd0, 3'd3);
        end
        step(0, 0, 1, 0, 5'b00011, 5'b00010, 2'd1, 3'd1, 3'd0, 2'd1, 3'd0);
        step(0, 0, 1, 0, 5'b00001, 5'b00001, 2'd1, 3'd0, 3'd0, 2'd1, 3'd4);
        step(0, 0, 1, 0, 5'b00000, 5'b00000, 2'd0, 3'd0, 3'd0, 2'd0, 3'd4);

        // Reset in mid-operation restores the pointer to N-1.
        step(0, 0, 0, 0, 5'b01000, 5'b01000, 2'd1, 3'd3, 3'd0, 2'd1, 3'd2);
        step(0, 1, 0, 0, 5'b01000, 5'b00000, 2'd0, 3'd0, 3'd0, 2'd0, 3'd4);
        step(0, 0, 1, 0, 5'b11111, 5'b10000, 2'd1, 3'd4, 3'd0, 2'd1, 3'd3);
        step(0, 0, 1, 0, 5'b00000, 5'b00000, 2'd0, 3'd0, 3'd0, 2'd0, 3'd3);

        // Dual-port instance: fixed, then round robin with wrap, then stall.
        step(1, 1, 0, 0, 5'b00000, 5'b00000, 2'd0, 3'd0, 3'd0, 2'd0, 3'd4);
        step(1, 0, 0, 0, 5'b11111, 5'b11000, 2'd3, 3'd4, 3'd3, 2'd2, 3'd2);
        step(1, 0, 0, 0, 5'b00000, 5'b00000, 2'd0, 3'd0, 3'd0, 2'd0, 3'd2);
        step(1, 0, 0, 0, 5'b00100, 5'b00100, 2'd1, 3'd2, 3'd0, 2'd1, 3'd1);
        step(1, 0, 0, 0, 5'b00000, 5'b00000, 2'd0, 3'd0, 3'd0, 2'd0, 3'd1);
        step(1, 0, 1, 0, 5'b11111, 5'b00011, 2'd3, 3'd1, 3'd0, 2'd2, 3'd4);
        step(1, 0, 1, 0, 5'b11100, 5'b11000, 2'd3, 3'd4, 3'd3, 2'd2, 3'd2);
        step(1, 0, 1, 0, 5'b00000, 5'b00000, 2'd0, 3'd0, 3'd0, 2'd0, 3'd2);
        step(1, 0, 1, 1, 5'b00111, 5'b00000, 2'd0, 3'd0, 3'd0, 2'd0, 3'd2);
        step(1, 0, 1, 0, 5'b00111, 5'b00110, 2'd3, 3'd2, 3'd1, 2'd2, 3'd0);
        step(1, 0, 1, 0, 5'b00001, 5'b00001, 2'd1, 3'd0, 3'd0, 2'd1, 3'd4);
        step(1, 0, 1, 0, 5'b00000, 5'b00000, 2'd0, 3'd0, 3'd0, 2'd0, 3'd4);

        repeat (2) @(negedge clk);
        chk("sb_drained", 8'(sb.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
